// File: rtl/pipe_field_if.sv
// pipe_field_if: bundle between game control / renderer and the pipe field.
//   Start, Lost : game-control levels into the pipe field
//   PipePosX    : packed pipe X positions, pipe i at [i*X_W +: X_W]
//   PipePosY    : packed pipe gap Y values, same packing
//   Score       : pipes passed this run (saturating)
//   Step        : pixels moved per tick
//   Running     : high only while the field is scrolling
// master = game control / renderer side, slave = pipe_field.
interface pipe_field_if #(
  parameter int NUM_PIPES = 3,
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int SCORE_W   = 8
);
  logic                     Start;
  logic                     Lost;
  logic [NUM_PIPES*X_W-1:0] PipePosX;
  logic [NUM_PIPES*Y_W-1:0] PipePosY;
  logic [SCORE_W-1:0]       Score;
  logic [2:0]               Step;
  logic                     Running;

  modport master (
    output Start, Lost,
    input  PipePosX, PipePosY, Score, Step, Running
  );

  modport slave (
    input  Start, Lost,
    output PipePosX, PipePosY, Score, Step, Running
  );
endinterface

// File: rtl/pipe_field.sv
// pipe_field: multi-pipe scroller for Flappy.
//   Moves NUM_PIPES obstacles right-to-left by Step pixels every TICK_DIV
//   clocks, respawns a pipe off-screen with an LFSR-chosen gap once it runs
//   past X=0, scores pipes crossing BIRD_X and speeds up every LEVEL_EVERY
//   points.
// Ports:
//   Clk   : system clock
//   Reset : asynchronous active-low reset
//   bus   : pipe_field_if.slave (Start/Lost in; positions, score, step,
//           running out)
module pipe_field #(
  parameter int          NUM_PIPES   = 3,
  parameter int          X_W         = 11,
  parameter int          Y_W         = 10,
  parameter int          START_X     = 640,
  parameter int          SPACING     = 256,
  parameter int          TICK_DIV    = 500000,
  parameter int          GAP_MIN     = 75,
  parameter int          GAP_RANGE   = 300,
  parameter int          BIRD_X      = 160,
  parameter int          LEVEL_EVERY = 5,
  parameter int          MAX_STEP    = 4,
  parameter int          SCORE_W     = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic          Clk,
  input logic          Reset,
  pipe_field_if.slave  bus
);

  localparam int               CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]   WRAP_ADD   = X_W'(NUM_PIPES * SPACING);
  localparam logic [X_W-1:0]   BIRD_V     = X_W'(BIRD_X);
  localparam logic [SCORE_W-1:0] LEVEL_V  = SCORE_W'(LEVEL_EVERY);
  localparam logic [2:0]       STEP_MAX_V = 3'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [X_W-1:0]     x_r [NUM_PIPES];
  logic [Y_W-1:0]     y_r [NUM_PIPES];
  logic [SCORE_W-1:0] score_r;
  logic [2:0]         step_r;
  logic [15:0]        lfsr_r;
  logic               running_r;

  logic [X_W-1:0]     x_tick_s [NUM_PIPES];
  logic [Y_W-1:0]     y_tick_s [NUM_PIPES];
  logic [15:0]        lfsr_walk_s;
  logic [3:0]         pass_cnt_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [SCORE_W-1:0] score_tick_s;
  logic [2:0]         step_tick_s;
  logic               level_up_s;

  // Galois LFSR, taps x^16+x^14+x^13+x^11, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Fold the low 9 LFSR bits into [0, GAP_RANGE) and offset by GAP_MIN.
  function automatic logic [Y_W-1:0] gap_of(input logic [15:0] v);
    logic [8:0] r;
    if (v[8:0] < 9'(GAP_RANGE)) begin
      r = v[8:0];
    end else begin
      r = v[8:0] - 9'(GAP_RANGE);
    end
    return Y_W'(GAP_MIN) + Y_W'(r);
  endfunction

  function automatic logic [X_W-1:0] x_init(input int i);
    return X_W'(START_X + i * SPACING);
  endfunction

  function automatic logic [Y_W-1:0] y_init(input int i);
    return Y_W'(GAP_MIN + i * 32);
  endfunction

  // Next positions, score and step assuming the current cycle is a tick.
  always_comb begin
    lfsr_walk_s = lfsr_r;
    pass_cnt_s  = 4'd0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (x_r[i] >= X_W'(step_r)) begin
        x_tick_s[i] = x_r[i] - X_W'(step_r);
        y_tick_s[i] = y_r[i];
        if ((x_r[i] > BIRD_V) && (x_tick_s[i] <= BIRD_V)) begin
          pass_cnt_s = pass_cnt_s + 4'd1;
        end else begin
          pass_cnt_s = pass_cnt_s;
        end
      end else begin
        // Wrap modulo 2^X_W; each wrapping pipe consumes the next LFSR value.
        x_tick_s[i] = x_r[i] - X_W'(step_r) + WRAP_ADD;
        y_tick_s[i] = gap_of(lfsr_walk_s);
        lfsr_walk_s = lfsr_next(lfsr_walk_s);
      end
    end
    score_sum_s = {1'b0, score_r} + (SCORE_W + 1)'(pass_cnt_s);
    if (score_sum_s[SCORE_W]) begin
      score_tick_s = '1;
    end else begin
      score_tick_s = score_sum_s[SCORE_W-1:0];
    end
    level_up_s = (score_tick_s > score_r) && ((score_tick_s % LEVEL_V) == '0);
    if (level_up_s && (step_r < STEP_MAX_V)) begin
      step_tick_s = step_r + 3'd1;
    end else begin
      step_tick_s = step_r;
    end
  end

  // Game FSM with tick divider; all outputs are registers updated here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
      cnt_r     <= '0;
      score_r   <= '0;
      step_r    <= 3'd1;
      lfsr_r    <= LFSR_SEED;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_r[i] <= x_init(i);
        y_r[i] <= y_init(i);
      end
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r   <= '0;
          score_r <= '0;
          step_r  <= 3'd1;
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_r[i] <= x_init(i);
            y_r[i] <= y_init(i);
          end
          if (bus.Start) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            running_r <= 1'b0;
          end
        end
        RUN: begin
          if (bus.Lost) begin
            // Lost wins over a coincident tick: nothing moves this cycle.
            state_r   <= LOST;
            running_r <= 1'b0;
          end else begin
            state_r   <= RUN;
            running_r <= 1'b1;
            if (cnt_r == TICK_LAST) begin
              cnt_r   <= '0;
              score_r <= score_tick_s;
              step_r  <= step_tick_s;
              lfsr_r  <= lfsr_walk_s;
              for (int i = 0; i < NUM_PIPES; i++) begin
                x_r[i] <= x_tick_s[i];
                y_r[i] <= y_tick_s[i];
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        LOST: begin
          running_r <= 1'b0;
          if (bus.Start) begin
            // Reinitialise on the way into IDLE so IDLE shows init values.
            state_r <= IDLE;
            cnt_r   <= '0;
            score_r <= '0;
            step_r  <= 3'd1;
            for (int i = 0; i < NUM_PIPES; i++) begin
              x_r[i] <= x_init(i);
              y_r[i] <= y_init(i);
            end
          end else begin
            state_r <= LOST;
          end
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

  // Pack the per-pipe registers onto the output buses.
  always_comb begin
    bus.PipePosX = '0;
    bus.PipePosY = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      bus.PipePosX[i*X_W +: X_W] = x_r[i];
      bus.PipePosY[i*Y_W +: Y_W] = y_r[i];
    end
    bus.Score   = score_r;
    bus.Step    = step_r;
    bus.Running = running_r;
  end

endmodule

// File: tb/tb_pipe_field.sv
module tb_pipe_field;
  localparam int NP = 3, XW = 11, YW = 10, SW = 8, TD = 4;
  localparam int START_X = 640, SPACING = 256, GAP_MIN = 75, GAP_RANGE = 300;
  localparam int BIRD_X = 160, LEVEL_EVERY = 5, MAX_STEP = 4;

  typedef struct packed {
    logic [NP*XW-1:0] x;
    logic [NP*YW-1:0] y;
    logic [SW-1:0]    score;
    logic [2:0]       step;
    logic             running;
  } obs_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  pipe_field_if #(.NUM_PIPES(NP), .X_W(XW), .Y_W(YW), .SCORE_W(SW)) bus_if ();

  pipe_field #(
    .NUM_PIPES(NP), .X_W(XW), .Y_W(YW), .START_X(START_X), .SPACING(SPACING),
    .TICK_DIV(TD), .GAP_MIN(GAP_MIN), .GAP_RANGE(GAP_RANGE), .BIRD_X(BIRD_X),
    .LEVEL_EVERY(LEVEL_EVERY), .MAX_STEP(MAX_STEP), .SCORE_W(SW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Reference model: game state as plain integers (0 idle, 1 run, 2 lost).
  int m_st, m_cnt, m_score, m_step;
  int m_x[NP];
  int m_y[NP];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    if (v[0]) return (v >> 1) ^ 16'hB400;
    else return v >> 1;
  endfunction

  task automatic model_init();
    for (int i = 0; i < NP; i++) begin
      m_x[i] = START_X + i * SPACING;
      m_y[i] = GAP_MIN + i * 32;
    end
    m_score = 0;
    m_step  = 1;
    m_cnt   = 0;
  endtask

  task automatic model_reset();
    model_init();
    m_st   = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_tick();
    int old_score, passed, nx, r;
    logic [15:0] l;
    old_score = m_score;
    passed = 0;
    l = m_lfsr;
    for (int i = 0; i < NP; i++) begin
      if (m_x[i] >= m_step) begin
        nx = m_x[i] - m_step;
        if (m_x[i] > BIRD_X && nx <= BIRD_X) passed++;
        m_x[i] = nx;
      end else begin
        m_x[i] = (m_x[i] - m_step + NP * SPACING) % (1 << XW);
        r = int'(l & 16'h01FF);
        if (r >= GAP_RANGE) r = r - GAP_RANGE;
        m_y[i] = GAP_MIN + r;
        l = lfsr_adv(l);
      end
    end
    m_lfsr = l;
    m_score = (old_score + passed > 255) ? 255 : old_score + passed;
    if (m_score > old_score && (m_score % LEVEL_EVERY) == 0 && m_step < MAX_STEP)
      m_step++;
  endtask

  task automatic model_step(input bit s, input bit l);
    case (m_st)
      0: begin
        model_init();
        if (s) m_st = 1;
      end
      1: begin
        if (l) m_st = 2;
        else if (m_cnt == TD - 1) begin
          m_cnt = 0;
          model_tick();
        end else m_cnt++;
      end
      default: begin
        if (s) begin
          m_st = 0;
          model_init();
        end
      end
    endcase
  endtask

  function automatic obs_t snap();
    obs_t o;
    for (int i = 0; i < NP; i++) begin
      o.x[i*XW +: XW] = XW'(m_x[i]);
      o.y[i*YW +: YW] = YW'(m_y[i]);
    end
    o.score   = SW'(m_score);
    o.step    = 3'(m_step);
    o.running = (m_st == 1);
    return o;
  endfunction

  function automatic obs_t init_obs();
    obs_t o;
    for (int i = 0; i < NP; i++) begin
      o.x[i*XW +: XW] = XW'(START_X + i * SPACING);
      o.y[i*YW +: YW] = YW'(GAP_MIN + i * 32);
    end
    o.score = '0;
    o.step = 3'd1;
    o.running = 1'b0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = bus_if.PipePosX;
    o.y = bus_if.PipePosY;
    o.score = bus_if.Score;
    o.step = bus_if.Step;
    o.running = bus_if.Running;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t got x=%h y=%h score=%0d step=%0d run=%b exp x=%h y=%h score=%0d step=%0d run=%b",
               name, $time, got.x, got.y, got.score, got.step, got.running,
               e.x, e.y, e.score, e.step, e.running);
    end
  endtask

  task automatic check_val(input string name, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, got, e);
    end
  endtask

  // Monitor: every clock the DUT presents a fresh output set; pop and compare.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) check_obs("scoreboard", dut_obs(), exp_q.pop_front());
    end
  end

  task automatic drive_now(input bit s, input bit l);
    bus_if.Start = s;
    bus_if.Lost = l;
    model_step(s, l);
    exp_q.push_back(snap());
  endtask

  task automatic cycle(input bit s, input bit l);
    @(negedge Clk);
    drive_now(s, l);
  endtask

  task automatic hold_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      bus_if.Start = 1'($urandom_range(0, 1));
      bus_if.Lost = 1'($urandom_range(0, 1));
      model_reset();
      exp_q.push_back(snap());
    end
    @(negedge Clk);
    Reset = 1'b1;
    drive_now(1'b0, 1'b0);
  endtask

  task automatic run_to_tick_slot(input string name);
    int n = 0;
    while (!(m_st == 1 && m_cnt == TD - 1) && n < 100) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check_val(name, int'(m_st == 1 && m_cnt == TD - 1), 1);
  endtask

  initial begin
    bus_if.Start = 1'b0;
    bus_if.Lost = 1'b0;
    model_reset();
    #1 Reset = 1'b0;
    #1 check_obs("reset_init", dut_obs(), init_obs());
    hold_reset(3);

    // Idle: Lost is ignored, nothing moves.
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'($urandom_range(0, 1)));
    @(posedge Clk); #2;
    check_obs("idle_hold", dut_obs(), init_obs());

    // Start pulse then four ticks.
    cycle(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0);
    @(posedge Clk); #2;
    check_val("x0_after_4_ticks", int'(bus_if.PipePosX[0 +: XW]), 636);
    check_val("x1_after_4_ticks", int'(bus_if.PipePosX[XW +: XW]), 892);
    check_val("x2_after_4_ticks", int'(bus_if.PipePosX[2*XW +: XW]), 1148);
    check_val("running_in_run", int'(bus_if.Running), 1);

    // Long run: wraps, passes, speed-up to saturation.
    for (int k = 0; k < 30000; k++) cycle(1'($urandom_range(0, 1)), 1'b0);
    @(posedge Clk); #2;
    check_val("step_saturated", int'(bus_if.Step), MAX_STEP);
    check_val("score_reached_15", int'(bus_if.Score >= 8'd15), 1);

    // Lost and Start together on a tick cycle.
    run_to_tick_slot("reach_tick_slot");
    cycle(1'b1, 1'b1);
    @(posedge Clk); #2;
    check_val("lost_running_low", int'(bus_if.Running), 0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'($urandom_range(0, 1)));
    cycle(1'b1, 1'b0);
    @(posedge Clk); #2;
    check_obs("lost_to_idle_init", dut_obs(), init_obs());
    cycle(1'b1, 1'b0);
    @(posedge Clk); #2;
    check_val("idle_to_run", int'(bus_if.Running), 1);

    // Random control traffic.
    for (int k = 0; k < 3000; k++)
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0));

    // Asynchronous reset in the middle of a tick cycle.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
    run_to_tick_slot("reach_tick_slot2");
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_obs("async_reset", dut_obs(), init_obs());
    model_reset();
    hold_reset(2);
    for (int k = 0; k < 30; k++) cycle(1'($urandom_range(0, 1)), 1'b0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    check_val("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
